// File: rtl/knn_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : knn_mem_pkg
//  Purpose  : Shared definitions for the KNN memory path. Holds the responder
//             state encoding, default geometry, and the helpers that turn a
//             bit address into a word index.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package knn_mem_pkg;

   localparam int DEF_W      = 16;
   localparam int DEF_ADDR_W = 25;
   localparam int DEF_DEPTH  = 2048;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_BUSY = 2'd2
   } state_t;

   // Exact for powers of two, which is all W is allowed to be.
   function automatic int log2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) <= value) r = i;
      end
      return r;
   endfunction

   // Addresses are bit offsets; one word spans w bits.
   function automatic logic [63:0] addr_to_index(input logic [63:0] addr, input int w);
      return addr >> log2(w);
   endfunction

   function automatic logic addr_in_range(input logic [63:0] addr, input int w, input int depth);
      return addr_to_index(addr, w) < 64'(depth);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_resp_array.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_resp_array
//  Purpose  : W x DEPTH word store with one synchronous write port and one
//             asynchronous read port. Contents are never reset.
//  Ports    : clk   - clock
//             we    - write enable
//             waddr - write word index
//             wdata - write word
//             raddr - read word index
//             rdata - combinational read word
//  Revision : 1.0 - initial release
// ============================================================================
module sdram_resp_array #(
   parameter int W     = 16,
   parameter int DEPTH = 2048,
   parameter int AW    = 11
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // A separate read index lets a read response and a newly accepted write
   // share one edge: the response sees the contents from before that write.
   assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/sdram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_responder
//  Purpose  : Slave end of memory_control's read/write request interface.
//             Serves rising-edge requests from an internal word array with an
//             SDRAM-like CAS read latency and a fixed write busy period. One
//             pending slot per request type absorbs requests made while busy.
//             Optional statistics outputs: define SDRAM_RESPONDER_STATS_EN.
//  Ports    : clk, rst (async, active-low)
//             read/readaddress, write/writeaddress/writedata - request side
//             readdata, readdatavalid                        - read response
//             busy, addr_error (sticky), overrun (sticky)    - status
//             read_count, write_count (stats build only)     - accept counts
//  Revision : 1.0 - initial release
// ============================================================================
module sdram_responder
   import knn_mem_pkg::*;
#(
   parameter int W            = DEF_W,
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DEPTH        = DEF_DEPTH,
   parameter int CAS_LAT      = 2,
   parameter int WRITE_CYCLES = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              read,
   input  logic [ADDR_W-1:0] readaddress,
   input  logic              write,
   input  logic [ADDR_W-1:0] writeaddress,
   input  logic [W-1:0]      writedata,
   output logic [W-1:0]      readdata,
   output logic              readdatavalid,
   output logic              busy,
   output logic              addr_error,
   output logic              overrun
`ifdef SDRAM_RESPONDER_STATS_EN
   ,
   output logic [31:0]       read_count,
   output logic [31:0]       write_count
`endif
);

   localparam int SH = log2(W);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t            state, state_n;
   logic [7:0]        cnt, cnt_n;
   logic              read_q, write_q;
   logic              pend_rd, pend_rd_n;
   logic [ADDR_W-1:0] pend_rd_addr, pend_rd_addr_n;
   logic              pend_wr, pend_wr_n;
   logic [ADDR_W-1:0] pend_wr_addr, pend_wr_addr_n;
   logic [W-1:0]      pend_wr_data, pend_wr_data_n;
   logic [ADDR_W-1:0] cur_rd_addr, cur_rd_addr_n;

   logic              rd_edge, wr_edge, done, free, rd_resp;
   logic              serve_wr, serve_rd, wr_edge_used, rd_edge_used, ovr_set;
   logic [ADDR_W-1:0] wr_addr_sel, rd_addr_sel;
   logic [W-1:0]      wr_data_sel, arr_rdata;
   logic              wr_in_range, rd_in_range;

   assign rd_edge = read  & ~read_q;
   assign wr_edge = write & ~write_q;

   // The final busy edge doubles as an idle edge so back-to-back work starts
   // without a dead cycle.
   assign done    = (state != IDLE) && (cnt == 8'd0);
   assign free    = (state == IDLE) || done;
   assign rd_resp = (state == RD_WAIT) && (cnt == 8'd0);
   assign busy    = (state != IDLE);

   // A pending entry always outranks a new edge of the same type.
   assign wr_addr_sel = pend_wr ? pend_wr_addr : writeaddress;
   assign wr_data_sel = pend_wr ? pend_wr_data : writedata;
   assign rd_addr_sel = pend_rd ? pend_rd_addr : readaddress;

   assign wr_in_range = addr_in_range(64'(wr_addr_sel), W, DEPTH);
   assign rd_in_range = addr_in_range(64'(cur_rd_addr), W, DEPTH);

   always_comb begin
      state_n        = state;
      cnt_n          = cnt;
      pend_rd_n      = pend_rd;
      pend_rd_addr_n = pend_rd_addr;
      pend_wr_n      = pend_wr;
      pend_wr_addr_n = pend_wr_addr;
      pend_wr_data_n = pend_wr_data;
      cur_rd_addr_n  = cur_rd_addr;
      serve_wr       = 1'b0;
      serve_rd       = 1'b0;
      wr_edge_used   = 1'b0;
      rd_edge_used   = 1'b0;
      ovr_set        = 1'b0;

      if (free) begin
         if (pend_wr) begin
            serve_wr  = 1'b1;
            pend_wr_n = 1'b0;
         end else if (pend_rd) begin
            serve_rd  = 1'b1;
            pend_rd_n = 1'b0;
         end else if (wr_edge) begin
            serve_wr     = 1'b1;
            wr_edge_used = 1'b1;
         end else if (rd_edge) begin
            serve_rd     = 1'b1;
            rd_edge_used = 1'b1;
         end
      end

      // Unserved edges park in their slot; a slot still full after this
      // edge's service means the new edge is lost.
      if (wr_edge && !wr_edge_used) begin
         if (pend_wr_n) begin
            ovr_set = 1'b1;
         end else begin
            pend_wr_n      = 1'b1;
            pend_wr_addr_n = writeaddress;
            pend_wr_data_n = writedata;
         end
      end
      if (rd_edge && !rd_edge_used) begin
         if (pend_rd_n) begin
            ovr_set = 1'b1;
         end else begin
            pend_rd_n      = 1'b1;
            pend_rd_addr_n = readaddress;
         end
      end

      if (free) begin
         if (serve_wr) begin
            state_n = WR_BUSY;
            cnt_n   = 8'(WRITE_CYCLES - 1);
         end else if (serve_rd) begin
            state_n       = RD_WAIT;
            cnt_n         = 8'(CAS_LAT - 1);
            cur_rd_addr_n = rd_addr_sel;
         end else begin
            state_n = IDLE;
            cnt_n   = 8'd0;
         end
      end else begin
         cnt_n = cnt - 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= 8'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         read_q        <= 1'b0;
         write_q       <= 1'b0;
         pend_rd       <= 1'b0;
         pend_rd_addr  <= '0;
         pend_wr       <= 1'b0;
         pend_wr_addr  <= '0;
         pend_wr_data  <= '0;
         cur_rd_addr   <= '0;
         readdata      <= '0;
         readdatavalid <= 1'b0;
         addr_error    <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         read_q        <= read;
         write_q       <= write;
         pend_rd       <= pend_rd_n;
         pend_rd_addr  <= pend_rd_addr_n;
         pend_wr       <= pend_wr_n;
         pend_wr_addr  <= pend_wr_addr_n;
         pend_wr_data  <= pend_wr_data_n;
         cur_rd_addr   <= cur_rd_addr_n;
         readdatavalid <= rd_resp;
         if (rd_resp) readdata <= rd_in_range ? arr_rdata : '0;
         if ((serve_wr && !wr_in_range) || (rd_resp && !rd_in_range)) addr_error <= 1'b1;
         if (ovr_set) overrun <= 1'b1;
      end
   end

   sdram_resp_array #(
      .W     (W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .we    (serve_wr && wr_in_range),
      .waddr (wr_addr_sel[SH +: AW]),
      .wdata (wr_data_sel),
      .raddr (cur_rd_addr[SH +: AW]),
      .rdata (arr_rdata)
   );

`ifdef SDRAM_RESPONDER_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         read_count  <= '0;
         write_count <= '0;
      end else begin
         if (serve_rd && (read_count != '1))  read_count  <= read_count + 32'd1;
         if (serve_wr && (write_count != '1)) write_count <= write_count + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_responder
//  Purpose  : Randomized and directed bench for sdram_responder with a
//             timestamp-based transaction model and a response scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_responder;

   localparam int W = 16, ADDR_W = 25, DEPTH = 2048, CAS_LAT = 2, WRITE_CYCLES = 8;

   logic              clk = 1'b0, rst = 1'b0, read = 1'b0, write = 1'b0;
   logic [ADDR_W-1:0] readaddress = '0, writeaddress = '0;
   logic [W-1:0]      writedata = '0;
   logic [W-1:0]      readdata;
   logic              readdatavalid, busy, addr_error, overrun;

   sdram_responder #(
      .W(W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CAS_LAT(CAS_LAT), .WRITE_CYCLES(WRITE_CYCLES)
   ) dut (
      .clk(clk), .rst(rst), .read(read), .readaddress(readaddress),
      .write(write), .writeaddress(writeaddress), .writedata(writedata),
      .readdata(readdata), .readdatavalid(readdatavalid), .busy(busy),
      .addr_error(addr_error), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   // ---------------- reference model ----------------
   typedef struct { logic [W-1:0] data; int t; } exp_t;
   exp_t            sb[$];
   logic [W-1:0]    mem_m [int];
   int              free_at = 0;
   bit              m_pw = 0, m_pr = 0, m_aerr = 0, m_ovr = 0;
   logic [ADDR_W-1:0] m_pwa, m_pra;
   logic [W-1:0]    m_pwd;
   bit              prev_rd = 0, prev_wr = 0;
   int              checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic accept_write(input int t, input logic [ADDR_W-1:0] a, input logic [W-1:0] d);
      int idx;
      idx = int'(a / W);
      if (idx < DEPTH) mem_m[idx] = d;
      else m_aerr = 1;
      free_at = t + WRITE_CYCLES;
   endtask

   task automatic accept_read(input int t, input logic [ADDR_W-1:0] a);
      int   idx;
      exp_t e;
      idx = int'(a / W);
      if (idx < DEPTH) e.data = mem_m[idx];
      else begin
         e.data = '0;
         m_aerr = 1;
      end
      e.t = t + CAS_LAT;
      sb.push_back(e);
      free_at = t + CAS_LAT;
   endtask

   // Server is free from free_at onward; one request served per free edge.
   task automatic model_step(input int t, input bit we, input logic [ADDR_W-1:0] wa,
                             input logic [W-1:0] wd, input bit re, input logic [ADDR_W-1:0] ra);
      bit used_w, used_r;
      used_w = 0;
      used_r = 0;
      if (t >= free_at) begin
         if (m_pw) begin
            m_pw = 0;
            accept_write(t, m_pwa, m_pwd);
         end else if (m_pr) begin
            m_pr = 0;
            accept_read(t, m_pra);
         end else if (we) begin
            used_w = 1;
            accept_write(t, wa, wd);
         end else if (re) begin
            used_r = 1;
            accept_read(t, ra);
         end
      end
      if (we && !used_w) begin
         if (m_pw) m_ovr = 1;
         else begin m_pw = 1; m_pwa = wa; m_pwd = wd; end
      end
      if (re && !used_r) begin
         if (m_pr) m_ovr = 1;
         else begin m_pr = 1; m_pra = ra; end
      end
   endtask

   task automatic cycle(input bit rd, input logic [ADDR_W-1:0] ra, input bit wr,
                        input logic [ADDR_W-1:0] wa, input logic [W-1:0] wd);
      bit re, we;
      @(negedge clk);
      chk("busy", 32'(busy), 32'(cyc < free_at));
      read = rd; readaddress = ra; write = wr; writeaddress = wa; writedata = wd;
      re = rd && !prev_rd;
      we = wr && !prev_wr;
      prev_rd = rd;
      prev_wr = wr;
      model_step(cyc + 1, we, wa, wd, re, ra);
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(0, '0, 0, '0, '0);
   endtask

   function automatic logic [ADDR_W-1:0] rand_addr();
      if ($urandom_range(0, 9) == 0) return ADDR_W'(32768 + $urandom_range(0, 63) * 16);
      return ADDR_W'($urandom_range(0, 255));
   endfunction

   // ---------------- monitor ----------------
   always begin : monitor
      exp_t e;
      @(posedge clk);
      #1;
      if (rst) begin
         if (readdatavalid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid: readdatavalid=1 at cycle %0d, required 0", cyc);
            end else begin
               e = sb.pop_front();
               chk("rd_data", 32'(readdata), 32'(e.data));
               chk("rd_cycle", cyc, e.t);
            end
         end else if (sb.size() > 0 && sb[0].t <= cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_valid: no response at cycle %0d, required one at cycle %0d", cyc, sb[0].t);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_readdata", 32'(readdata), 32'h0);
      chk("rst_valid", 32'(readdatavalid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_addr_error", 32'(addr_error), 32'h0);
      chk("rst_overrun", 32'(overrun), 32'h0);
      rst = 1'b1;

      // Preload words 0..15; word 5 (bit address 80) holds 0x002A.
      for (int i = 0; i < 16; i++) begin
         cycle(0, '0, 1, ADDR_W'(i * 16), (i == 5) ? 16'h002A : 16'((i * 16'h1111) ^ 16'h0F0F));
         idle(9);
      end

      // Read word 5 with CAS latency.
      cycle(1, 25'd80, 0, '0, '0);
      idle(5);

      // Write then read back.
      cycle(0, '0, 1, 25'd160, 16'hBEEF);
      idle(9);
      cycle(1, 25'd160, 0, '0, '0);
      idle(5);

      // Simultaneous write and read of the same word.
      cycle(1, 25'd32, 1, 25'd32, 16'd7);
      idle(13);
      chk("overrun_same_cycle", 32'(overrun), 32'h0);

      // Two read edges during one write busy period: second is dropped.
      cycle(0, '0, 1, 25'd48, 16'h4321);
      cycle(1, 25'd96, 0, '0, '0);
      cycle(0, '0, 0, '0, '0);
      cycle(1, 25'd112, 0, '0, '0);
      idle(14);
      chk("overrun_drop", 32'(overrun), 32'h1);
      chk("overrun_model", 32'(overrun), 32'(m_ovr));

      // Out-of-range read, then out-of-range write must not alias word 0.
      cycle(1, 25'd32768, 0, '0, '0);
      idle(5);
      chk("addr_error_rd", 32'(addr_error), 32'h1);
      cycle(0, '0, 1, 25'd32768, 16'h5555);
      idle(9);
      cycle(1, 25'd0, 0, '0, '0);
      idle(5);

      // Reset one cycle after a read is accepted.
      cycle(0, '0, 1, 25'd176, 16'h1234);
      idle(9);
      cycle(1, 25'd16, 0, '0, '0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      read = 1'b0;
      write = 1'b0;
      #1;
      chk("async_rst_readdata", 32'(readdata), 32'h0);
      chk("async_rst_valid", 32'(readdatavalid), 32'h0);
      chk("async_rst_busy", 32'(busy), 32'h0);
      chk("async_rst_addr_error", 32'(addr_error), 32'h0);
      chk("async_rst_overrun", 32'(overrun), 32'h0);
      sb.delete();
      m_pw = 0; m_pr = 0; m_aerr = 0; m_ovr = 0;
      free_at = 0;
      prev_rd = 0; prev_wr = 0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      idle(6);
      cycle(1, 25'd176, 0, '0, '0);
      idle(5);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 3) == 0, rand_addr(), $urandom_range(0, 4) == 0, rand_addr(), 16'($urandom));
      end
      idle(24);
      chk("sb_drained", 32'(sb.size()), 32'h0);
      chk("addr_error_final", 32'(addr_error), 32'(m_aerr));
      chk("overrun_final", 32'(overrun), 32'(m_ovr));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
